gray_to_binary_tracker: RTL and testbench

Receive-side counterpart to the binary-to-Gray converter. It samples a Gray-coded position or pointer bus from another domain or a sensor, synchronises it, and converts it to binary. It then classifies each change as one step up, one step down, or illegal, and keeps a saturating count of errors. It sits at the boundary where Gray-coded counters (async FIFO pointers, rotary encoders) enter the `clk` domain.

---
 rtl/gray_pkg.sv | 30 +++
 rtl/sync_ff.sv | 28 ++
 rtl/gray_to_binary_tracker.sv | 117 +++++++++++
 tb/tb_gray_to_binary_tracker.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-to-binary tracker.
// Gray decode, popcount and default error-counter width.
package gray_pkg;

  localparam int ERR_CNT_W_DEF = 8;
  localparam int MAX_W = 16;

  // Bit i of the binary value is the XOR of gray bits MAX_W-1..i.
  // Narrower words are zero-extended, which leaves the result exact.
  function automatic logic [MAX_W-1:0] g2b(
    input logic [MAX_W-1:0] gray
  );
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = gray[MAX_W-1];
    for (int i = MAX_W-2; i >= 0; i--)
      b[i] = b[i+1] ^ gray[i];
    return b;
  endfunction

  function automatic logic [4:0] popcount(
    input logic [MAX_W-1:0] v
  );
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_W; i++)
      n = n + 5'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop chain bringing an async bus into clk.
// Ports: clk, rst_n (async low), d in, q out after STAGES edges.
module sync_ff #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++)
        chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++)
        chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gray_to_binary_tracker.sv
// Synchronise a Gray bus, decode it, classify each change.
// Ports: clk, rst_n, gray_in, clear_err -> bin_out, bin_valid,
// step_up, step_down, err_multi, err_count.
module gray_to_binary_tracker
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = ERR_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 clear_err,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 step_up,
  output logic                 step_down,
  output logic                 err_multi,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int PW = 3;

  logic [WIDTH-1:0]     s;
  logic [WIDTH-1:0]     g_q;
  logic [PW-1:0]        pcnt;
  logic [WIDTH-1:0]     d;
  logic [WIDTH-1:0]     b_new;
  logic [WIDTH-1:0]     b_inc;
  logic [WIDTH-1:0]     b_dec;
  logic                 one_bit;

  logic [WIDTH-1:0]     g_q_n;
  logic [WIDTH-1:0]     bin_n;
  logic [PW-1:0]        pcnt_n;
  logic                 valid_n;
  logic                 up_n;
  logic                 dn_n;
  logic                 err_n;
  logic [ERR_CNT_W-1:0] ecnt_n;

  sync_ff #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gray_in),
    .q     (s)
  );

  assign d       = s ^ g_q;
  assign b_new   = WIDTH'(g2b(MAX_W'(s)));
  assign b_inc   = bin_out + WIDTH'(1);
  assign b_dec   = bin_out - WIDTH'(1);
  assign one_bit = popcount(MAX_W'(d)) == 5'd1;

  always_comb begin
    g_q_n   = g_q;
    bin_n   = bin_out;
    pcnt_n  = pcnt;
    valid_n = bin_valid;
    up_n    = 1'b0;
    dn_n    = 1'b0;
    err_n   = 1'b0;
    // The chain holds reset zeros until it has been refilled,
    // so the first real sample is taken only after that.
    if (!bin_valid) begin
      if (pcnt == PW'(SYNC_STAGES)) begin
        valid_n = 1'b1;
        g_q_n   = s;
        bin_n   = b_new;
      end else begin
        pcnt_n  = pcnt + PW'(1);
      end
    end else if (d != '0) begin
      g_q_n = s;
      bin_n = b_new;
      unique case (1'b1)
        one_bit && (b_new == b_inc): up_n  = 1'b1;
        one_bit && (b_new == b_dec): dn_n  = 1'b1;
        default:                     err_n = 1'b1;
      endcase
    end
  end

  // Clear first, then count this cycle's error on top of it.
  always_comb begin
    ecnt_n = clear_err ? '0 : err_count;
    if (err_n && (ecnt_n != '1))
      ecnt_n = ecnt_n + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q       <= '0;
      bin_out   <= '0;
      pcnt      <= '0;
      bin_valid <= 1'b0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      err_multi <= 1'b0;
      err_count <= '0;
    end else begin
      g_q       <= g_q_n;
      bin_out   <= bin_n;
      pcnt      <= pcnt_n;
      bin_valid <= valid_n;
      step_up   <= up_n;
      step_down <= dn_n;
      err_multi <= err_n;
      err_count <= ecnt_n;
    end
  end

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// Scoreboard bench for gray_to_binary_tracker.
// Driver queues expected events; a negedge monitor checks them.
module tb_gray_to_binary_tracker;

  typedef enum int {K_PRIME, K_UP, K_DOWN, K_ERR} kind_e;
  typedef struct {
    kind_e k;
    logic [3:0] b;
    int e;
    int at;
  } exp_t;

  logic       clk = 0;
  logic       rst_n = 0;
  logic [3:0] gray_in = 4'b0110;
  logic       clear_err = 0;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic       step_up;
  logic       step_down;
  logic       err_multi;
  logic [7:0] err_count;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   m_err = 0;
  bit   prev_v = 0;
  exp_t q[$];

  gray_to_binary_tracker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_in   (gray_in),
    .clear_err (clear_err),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .step_up   (step_up),
    .step_down (step_down),
    .err_multi (err_multi),
    .err_count (err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input kind_e k, input logic [3:0] b);
    exp_t x;
    x.k = k; x.b = b; x.e = m_err; x.at = cyc + 3;
    q.push_back(x);
  endtask

  task automatic drive(input logic [3:0] g, input kind_e k,
                       input logic [3:0] b, input bit clr);
    @(posedge clk); #1;
    gray_in = g;
    if (k == K_ERR) begin
      if (clr) m_err = 0;
      if (m_err != 255) m_err++;
    end
    expect_ev(k, b);
  endtask

  function automatic logic [3:0] to_gray(input int i);
    logic [3:0] v;
    v = 4'(i);
    return v ^ (v >> 1);
  endfunction

  always @(negedge clk) begin
    bit pr;
    int np;
    kind_e k;
    exp_t x;
    pr = bin_valid && !prev_v;
    prev_v = bin_valid;
    np = int'(step_up) + int'(step_down) + int'(err_multi);
    if (np > 1) begin
      total++; bad++;
      $display("FAIL excl: %0d pulses at cyc %0d", np, cyc);
    end
    if (pr || np != 0) begin
      k = pr ? K_PRIME : step_up ? K_UP : step_down ? K_DOWN : K_ERR;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected: kind %0d bin %0d at cyc %0d",
                 k, bin_out, cyc);
      end else begin
        x = q.pop_front();
        if (k != x.k || bin_out != x.b || int'(err_count) != x.e
            || cyc != x.at || (pr && np != 0)) begin
          bad++;
          $display("FAIL event: got k%0d b%0d e%0d c%0d want k%0d b%0d e%0d c%0d",
                   k, bin_out, err_count, cyc, x.k, x.b, x.e, x.at);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_bin", int'(bin_out), 0);
    check("rst_valid", int'(bin_valid), 0);
    check("rst_pulses", int'({step_up, step_down, err_multi}), 0);
    check("rst_err", int'(err_count), 0);
    rst_n = 1;
    expect_ev(K_PRIME, 4'd4);
    @(posedge clk); @(negedge clk);
    check("prime_e1", int'(bin_valid), 0);
    @(posedge clk); @(negedge clk);
    check("prime_e2", int'(bin_valid), 0);
    repeat (3) @(posedge clk);

    #1 rst_n = 0; gray_in = 4'b0000;
    @(posedge clk); #1 rst_n = 1;
    expect_ev(K_PRIME, 4'd0);
    repeat (4) @(posedge clk);

    for (int i = 1; i <= 16; i++) begin
      drive(to_gray(i), K_UP, 4'(i), 0);
      repeat (3) @(posedge clk);
    end
    @(negedge clk);
    check("up_err", int'(err_count), 0);

    drive(4'b0001, K_UP, 4'd1, 0);
    drive(4'b0011, K_UP, 4'd2, 0);
    drive(4'b0001, K_DOWN, 4'd1, 0);
    drive(4'b0000, K_DOWN, 4'd0, 0);
    drive(4'b1000, K_DOWN, 4'd15, 0);

    drive(4'b0000, K_UP, 4'd0, 0);
    drive(4'b0001, K_UP, 4'd1, 0);
    drive(4'b1001, K_ERR, 4'd14, 0);
    drive(4'b1000, K_UP, 4'd15, 0);
    drive(4'b0000, K_UP, 4'd0, 0);
    drive(4'b0101, K_ERR, 4'd6, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("err_two", int'(err_count), 2);

    for (int i = 1; i <= 300; i++) begin
      if (i % 2 == 1) drive(4'b0000, K_ERR, 4'd0, 0);
      else            drive(4'b0101, K_ERR, 4'd6, 0);
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("sat_hold", int'(err_count), 255);

    @(posedge clk); #1 clear_err = 1;
    @(posedge clk); #1 clear_err = 0;
    m_err = 0;
    @(negedge clk);
    check("clear_alone", int'(err_count), 0);

    drive(4'b0000, K_ERR, 4'd0, 1);
    repeat (2) @(posedge clk);
    #1 clear_err = 1;
    @(posedge clk); #1 clear_err = 0;
    @(negedge clk);
    check("clear_err_same", int'(err_count), 1);
    repeat (3) @(posedge clk);

    drive(4'b0001, K_UP, 4'd1, 0);
    drive(4'b0011, K_UP, 4'd2, 0);
    repeat (4) @(posedge clk);
    @(posedge clk); #1 gray_in = 4'b0010;
    #2 rst_n = 0;
    #1;
    check("mid_bin", int'(bin_out), 0);
    check("mid_valid", int'(bin_valid), 0);
    check("mid_pulses", int'({step_up, step_down, err_multi}), 0);
    check("mid_err", int'(err_count), 0);
    #2 rst_n = 1;
    m_err = 0;
    expect_ev(K_PRIME, 4'd3);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
